// File: rtl/prefetch_queue_8088.sv
// 8088-style instruction prefetch queue: a 4-byte code FIFO that fetches one byte
// per bus cycle from CS:IP and hands the two oldest bytes to the decoder.
module prefetch_queue_8088 (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cs,
  input  logic        flush,
  input  logic [15:0] new_ip,
  output logic        bus_req,
  output logic [19:0] bus_addr,
  input  logic        bus_ack,
  input  logic [7:0]  bus_data,
  input  logic [1:0]  consume,
  output logic [2:0]  q_count,
  output logic [7:0]  q_byte0,
  output logic [7:0]  q_byte1,
  output logic [15:0] ip_out
);

  typedef enum logic {
    IDLE,
    REQ
  } fetch_state_t;

  fetch_state_t state, state_next;

  logic [7:0]  mem [4];
  logic [1:0]  rd_ptr;
  logic [1:0]  wr_ptr;
  logic [2:0]  count;
  logic [2:0]  count_next;
  logic [15:0] fetch_ip;
  logic [15:0] ip_reg;
  logic [2:0]  pop_n;
  logic        push;

  // A request for more bytes than are held (or the reserved code 3) pops nothing.
  always_comb begin
    pop_n = '0;
    if (consume != 2'd3 && {1'b0, consume} <= count)
      pop_n = {1'b0, consume};
  end

  assign push       = (state == REQ) && bus_ack && !flush && (count != 3'd4);
  assign count_next = count + {2'b00, push} - pop_n;

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (count < 3'd4) state_next = REQ;
        REQ:  if (bus_ack) state_next = (count_next < 3'd4) ? REQ : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      fetch_ip <= '0;
      ip_reg   <= '0;
      for (int unsigned i = 0; i < 4; i++)
        mem[i] <= '0;
    end else if (flush) begin
      state    <= IDLE;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      fetch_ip <= new_ip;
      ip_reg   <= new_ip;
    end else begin
      state  <= state_next;
      count  <= count_next;
      rd_ptr <= rd_ptr + pop_n[1:0];
      ip_reg <= ip_reg + {13'd0, pop_n};
      if (push) begin
        mem[wr_ptr] <= bus_data;
        wr_ptr      <= wr_ptr + 2'd1;
        fetch_ip    <= fetch_ip + 16'd1;
      end
    end
  end

  // Segment carry above bit 19 falls off, giving the real-mode 1MB wrap.
  assign bus_addr = {cs, 4'h0} + {4'h0, fetch_ip};
  assign bus_req  = (state == REQ);
  assign q_count  = count;
  assign q_byte0  = (count != 3'd0) ? mem[rd_ptr] : 8'h00;
  assign q_byte1  = (count >= 3'd2) ? mem[rd_ptr + 2'd1] : 8'h00;
  assign ip_out   = ip_reg;

endmodule

// File: tb/tb_prefetch_queue_8088.sv
// Bench for prefetch_queue_8088: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a queue-based reference model.
module tb_prefetch_queue_8088;

  logic        clk;
  logic        reset;
  logic [15:0] cs;
  logic        flush;
  logic [15:0] new_ip;
  logic        bus_req;
  logic [19:0] bus_addr;
  logic        bus_ack;
  logic [7:0]  bus_data;
  logic [1:0]  consume;
  logic [2:0]  q_count;
  logic [7:0]  q_byte0;
  logic [7:0]  q_byte1;
  logic [15:0] ip_out;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  mq[$];
  logic [15:0] m_fip;
  logic [15:0] m_ipo;
  bit          m_req;

  prefetch_queue_8088 dut (
    .clk      (clk),
    .reset    (reset),
    .cs       (cs),
    .flush    (flush),
    .new_ip   (new_ip),
    .bus_req  (bus_req),
    .bus_addr (bus_addr),
    .bus_ack  (bus_ack),
    .bus_data (bus_data),
    .consume  (consume),
    .q_count  (q_count),
    .q_byte0  (q_byte0),
    .q_byte1  (q_byte1),
    .ip_out   (ip_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_fip = 16'h0000;
    m_ipo = 16'h0000;
    m_req = 1'b0;
  endtask

  // One rising edge of the reference: pop by consume if legal, accept the byte if a
  // request was outstanding, then decide whether a request is outstanding next cycle.
  task automatic model_update();
    int unsigned c, n;
    if (!reset) begin
      model_reset();
      return;
    end
    if (flush) begin
      mq.delete();
      m_fip = new_ip;
      m_ipo = new_ip;
      m_req = 1'b0;
      return;
    end
    c = mq.size();
    n = (consume != 2'd3 && consume <= c) ? consume : 0;
    repeat (n) void'(mq.pop_front());
    m_ipo = m_ipo + 16'(n);
    if (m_req) begin
      if (bus_ack) begin
        mq.push_back(bus_data);
        m_fip = m_fip + 16'd1;
        m_req = (mq.size() < 4);
      end
    end else begin
      m_req = (c < 4);
    end
  endtask

  task automatic compare_all();
    logic [31:0] addr;
    addr = (({16'h0, cs} << 4) + {16'h0, m_fip}) & 32'h000F_FFFF;
    check("bus_req",  {31'd0, bus_req}, {31'd0, m_req});
    check("bus_addr", {12'd0, bus_addr}, addr);
    check("q_count",  {29'd0, q_count}, mq.size());
    check("q_byte0",  {24'd0, q_byte0}, (mq.size() > 0) ? {24'd0, mq[0]} : 32'd0);
    check("q_byte1",  {24'd0, q_byte1}, (mq.size() > 1) ? {24'd0, mq[1]} : 32'd0);
    check("ip_out",   {16'd0, ip_out}, {16'd0, m_ipo});
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic async_reset();
    #2 reset = 1'b0;
    #1 check("async_reset_bus_req", {31'd0, bus_req}, 32'd0);
    model_reset();
    bus_ack  = 1'b1;
    bus_data = 8'hBB;
    step();
    bus_ack = 1'b0;
    reset   = 1'b1;
  endtask

  initial begin
    reset    = 1'b0;
    cs       = 16'hF000;
    flush    = 1'b0;
    new_ip   = 16'h0000;
    bus_ack  = 1'b0;
    bus_data = 8'h00;
    consume  = 2'd0;
    model_reset();
    step();
    step();
    check("reset_addr", {12'd0, bus_addr}, 32'h000F_0000);
    check("reset_count", {29'd0, q_count}, 32'd0);
    reset = 1'b1;
    check("release_no_req", {31'd0, bus_req}, 32'd0);
    step();
    check("first_req", {31'd0, bus_req}, 32'd1);

    // Fill
    for (int i = 0; i < 4; i++) begin
      check("fill_addr", {12'd0, bus_addr}, 32'h000F_0000 + 32'(i));
      bus_ack  = 1'b1;
      bus_data = 8'(8'h11 * (i + 1));
      step();
    end
    bus_ack = 1'b0;
    check("fill_count", {29'd0, q_count}, 32'd4);
    check("fill_b0", {24'd0, q_byte0}, 32'h11);
    check("fill_b1", {24'd0, q_byte1}, 32'h22);
    check("fill_req", {31'd0, bus_req}, 32'd0);

    // Drain
    consume = 2'd2;
    step();
    check("drain_b0", {24'd0, q_byte0}, 32'h33);
    check("drain_ip", {16'd0, ip_out}, 32'h0002);
    consume = 2'd1;
    step();
    consume = 2'd0;
    check("drain2_b0", {24'd0, q_byte0}, 32'h44);
    check("drain2_ip", {16'd0, ip_out}, 32'h0003);
    check("refetch_req", {31'd0, bus_req}, 32'd1);
    check("refetch_addr", {12'd0, bus_addr}, 32'h000F_0004);

    // Simultaneous push and pop at count 3
    bus_ack = 1'b1; bus_data = 8'hA1; step();
    bus_data = 8'hA2; step();
    check("sim_pre_count", {29'd0, q_count}, 32'd3);
    consume = 2'd1; bus_data = 8'h55; step();
    bus_ack = 1'b0; consume = 2'd0;
    check("sim_count", {29'd0, q_count}, 32'd3);
    check("sim_ip", {16'd0, ip_out}, 32'h0004);
    check("sim_b0", {24'd0, q_byte0}, 32'hA1);

    // Flush at count 2 with a concurrent ack
    consume = 2'd1; step();
    consume = 2'd0;
    check("flush_pre_b1", {24'd0, q_byte1}, 32'h55);
    flush = 1'b1; new_ip = 16'h1234; cs = 16'h0100; bus_ack = 1'b1; bus_data = 8'hEE;
    step();
    flush = 1'b0; bus_ack = 1'b0;
    check("flush_count", {29'd0, q_count}, 32'd0);
    check("flush_ip", {16'd0, ip_out}, 32'h1234);
    check("flush_idle", {31'd0, bus_req}, 32'd0);
    step();
    check("flush_req", {31'd0, bus_req}, 32'd1);
    check("flush_addr", {12'd0, bus_addr}, 32'h0000_2234);
    bus_ack = 1'b1; bus_data = 8'h77; step();
    bus_ack = 1'b0;
    check("flush_b0", {24'd0, q_byte0}, 32'h77);

    // Segment and offset wrap
    flush = 1'b1; new_ip = 16'hFFFF; cs = 16'hFFFF; step();
    flush = 1'b0; step();
    check("wrap_addr0", {12'd0, bus_addr}, 32'h0000_FFEF);
    bus_ack = 1'b1; bus_data = 8'h9C; step();
    bus_ack = 1'b0;
    check("wrap_addr1", {12'd0, bus_addr}, 32'h000F_FFF0);

    // Over-consume is ignored
    consume = 2'd2; step();
    check("illegal_count", {29'd0, q_count}, 32'd1);
    check("illegal_b0", {24'd0, q_byte0}, 32'h9C);
    check("illegal_ip", {16'd0, ip_out}, 32'hFFFF);
    consume = 2'd1; step();
    consume = 2'd0;
    check("ip_wrap", {16'd0, ip_out}, 32'h0000);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 299) == 0) async_reset();
      flush    = ($urandom_range(0, 29) == 0);
      new_ip   = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      if ($urandom_range(0, 49) == 0) cs = 16'($urandom);
      bus_ack  = 1'($urandom_range(0, 1));
      bus_data = 8'($urandom);
      consume  = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
